// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-requester writeback arbiter for the register-file write port
//
// Shares one register-file write port between the ALU result path (requester 0)
// and the load result path (requester 1). Arbitration is round-robin, with a
// starvation bound: a requester that has lost MAX_WAIT times in a row is forced
// to win. The grant is combinational. The write itself leaves through a register
// stage, so it appears one cycle after the handshake.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   req0_valid/addr/data       ALU writeback request
//   req0_ready                 ALU request accepted this cycle
//   req1_valid/addr/data       load writeback request
//   req1_ready                 load request accepted this cycle
//   regwrite                   register-file write enable (registered)
//   writeaddress, writedata    register-file write address/data (registered, held)
//   last_grant                 index of the most recently granted requester
module wb_port_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int MAX_WAIT    = 3,
    parameter int R0_WRITABLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              regwrite,
    output logic [ADDR_W-1:0] writeaddress,
    output logic [DATA_W-1:0] writedata,
    output logic              last_grant
);

    localparam logic [3:0] MAXW = 4'(MAX_WAIT);

    logic [3:0] wait0;
    logic [3:0] wait1;
    logic       grant0;
    logic       grant1;
    logic       xfer0;
    logic       xfer1;

    // A starved requester overrides round-robin. Both counters cannot be
    // saturated at the same time: whenever one requester loses, the other
    // requester's transfer clears that other requester's counter.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant0 = 1'b1;
        end else if (!req0_valid && req1_valid) begin
            grant1 = 1'b1;
        end else if (req0_valid && req1_valid) begin
            if (wait0 == MAXW) begin
                grant0 = 1'b1;
            end else if (wait1 == MAXW) begin
                grant1 = 1'b1;
            end else if (last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer0      = req0_valid && grant0;
    assign xfer1      = req1_valid && grant1;

    // A grant to register 0 is still consumed when R0 is not writable, but it
    // produces no write enable.
    function automatic logic addr_writes(input logic [ADDR_W-1:0] a);
        return (R0_WRITABLE != 0) || (a != '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite     <= 1'b0;
            writeaddress <= '0;
            writedata    <= '0;
            last_grant   <= 1'b1;
        end else if (xfer0) begin
            regwrite     <= addr_writes(req0_addr);
            writeaddress <= req0_addr;
            writedata    <= req0_data;
            last_grant   <= 1'b0;
        end else if (xfer1) begin
            regwrite     <= addr_writes(req1_addr);
            writeaddress <= req1_addr;
            writedata    <= req1_data;
            last_grant   <= 1'b1;
        end else begin
            regwrite     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait0 <= 4'd0;
            wait1 <= 4'd0;
        end else begin
            if (!req0_valid || xfer0) begin
                wait0 <= 4'd0;
            end else if (wait0 != MAXW) begin
                wait0 <= wait0 + 4'd1;
            end
            if (!req1_valid || xfer1) begin
                wait1 <= 4'd0;
            end else if (wait1 != MAXW) begin
                wait1 <= wait1 + 4'd1;
            end
        end
    end

endmodule
